// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side memory responder with RAM and MMIO window
//
// Purpose:
//   Serves the core's M-stage data port. It holds a word-organised data RAM
//   with byte-lane stores and sign/zero-extended loads. It also provides an
//   MMIO window containing a 64-bit cycle counter, a simulation exit register,
//   sticky error capture and an optional console TX FIFO.
//
// Optional feature macro: DMEM_CONSOLE_EN (console FIFO; absent -> stub)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   MemWriteM           store strobe
//   mem_sizeM[2:0]      funct3 size code (B/H/W/BU/HU)
//   ALUResultM[31:0]    byte address
//   WriteDataM[31:0]    store data, right-aligned
//   ReadDataM[31:0]     combinational load data, extended
//   halt, exit_code     sticky halt and the value written to EXIT
//   err, err_addr       sticky access error and first offending address
//   tx_valid, tx_data   console byte stream out
//   tx_ready            console sink ready
module dmem_responder #(
  parameter int unsigned DEPTH      = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [2:0]  mem_sizeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        halt,
  output logic [31:0] exit_code,
  output logic        err,
  output logic [31:0] err_addr,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OFF_CYCLE_LO = 3'd0;
  localparam logic [2:0] OFF_CYCLE_HI = 3'd1;
  localparam logic [2:0] OFF_EXIT     = 3'd2;
  localparam logic [2:0] OFF_CONS_TX  = 3'd3;
  localparam logic [2:0] OFF_CONS_ST  = 3'd4;
  localparam logic [2:0] OFF_ERR_ADDR = 3'd5;

  // ---------------------------------------------------------------------------
  // Address / size decode
  // ---------------------------------------------------------------------------
  logic [1:0]    lane;
  logic [AW-1:0] ram_idx;
  logic [2:0]    mmio_off;
  logic          in_mmio;
  logic          in_ram;
  logic          size_ok;
  logic          align_ok;
  logic          legal;

  assign lane     = ALUResultM[1:0];
  assign ram_idx  = ALUResultM[AW+1:2];
  assign mmio_off = ALUResultM[4:2];
  assign in_mmio  = (ALUResultM[31:16] == MMIO_BASE[31:16]);
  // MMIO takes priority should the two windows ever overlap.
  assign in_ram   = (ALUResultM[31:AW+2] == '0) && !in_mmio;

  always_comb begin
    size_ok  = 1'b0;
    align_ok = 1'b0;
    case (mem_sizeM)
      3'b000: begin size_ok = 1'b1;       align_ok = 1'b1;                end
      3'b001: begin size_ok = 1'b1;       align_ok = !ALUResultM[0];      end
      3'b010: begin size_ok = 1'b1;       align_ok = (lane == 2'b00);     end
      // Unsigned sizes only make sense for loads.
      3'b100: begin size_ok = !MemWriteM; align_ok = 1'b1;                end
      3'b101: begin size_ok = !MemWriteM; align_ok = !ALUResultM[0];      end
      default: begin size_ok = 1'b0;      align_ok = 1'b0;                end
    endcase
  end

  // MMIO registers are word-only; anything narrower is an error.
  assign legal = size_ok && align_ok && (!in_mmio || (mem_sizeM == 3'b010));

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic        halt_q, halt_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [63:0] cyc_q, cyc_d;

  logic store_ok;
  logic ram_we;
  logic exit_we;
  logic tx_we;

  // Every store side effect is blocked once halted or when the access is illegal.
  assign store_ok = MemWriteM && legal && !halt_q;
  assign ram_we   = store_ok && in_ram;
  assign exit_we  = store_ok && in_mmio && (mmio_off == OFF_EXIT);
  assign tx_we    = store_ok && in_mmio && (mmio_off == OFF_CONS_TX);

  always_comb begin
    halt_d      = halt_q;
    exit_code_d = exit_code_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    cyc_d       = halt_q ? cyc_q : cyc_q + 64'd1;
    // Only the first offending address is kept.
    if (!legal && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = ALUResultM;
    end
    if (exit_we) begin
      halt_d      = 1'b1;
      exit_code_d = WriteDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q      <= 1'b0;
      exit_code_q <= 32'd0;
      err_q       <= 1'b0;
      err_addr_q  <= 32'd0;
      cyc_q       <= 64'd0;
    end else begin
      halt_q      <= halt_d;
      exit_code_q <= exit_code_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      cyc_q       <= cyc_d;
    end
  end

  assign halt      = halt_q;
  assign exit_code = exit_code_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

  // ---------------------------------------------------------------------------
  // Data RAM (not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [DEPTH];
  logic [3:0]  be;
  logic [31:0] wdata;

  // Replicating the store data across lanes places it under every possible
  // byte enable, so no barrel shift is needed on the write path.
  always_comb begin
    be    = 4'b1111;
    wdata = WriteDataM;
    case (mem_sizeM[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = WriteDataM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          ram_q[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Console FIFO
  // ---------------------------------------------------------------------------
  logic [31:0] status_rdata;

`ifdef DMEM_CONSOLE_EN
  localparam int         PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] FIFO_FULL = 5'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == 5'd0);
  assign fifo_pop   = !fifo_empty && tx_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign fifo_push  = tx_we && (!fifo_full || fifo_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    count_d  = count_q + 5'(fifo_push) - 5'(fifo_pop);
    if (fifo_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    if (fifo_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (tx_we && !fifo_push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_q[wr_ptr_q] <= WriteDataM[7:0];
    end
  end

  assign tx_valid     = !fifo_empty;
  assign tx_data      = fifo_empty ? 8'd0 : fifo_q[rd_ptr_q];
  assign status_rdata = {24'd0, count_q, ovf_q, fifo_empty, fifo_full};
`else
  logic unused_console;
  assign unused_console = &{1'b0, tx_ready, tx_we};
  assign tx_valid       = 1'b0;
  assign tx_data        = 8'd0;
  assign status_rdata   = 32'h0000_0002;
`endif

  // ---------------------------------------------------------------------------
  // Read path (combinational, side-effect free)
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_rdata;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  always_comb begin
    case (mmio_off)
      OFF_CYCLE_LO: mmio_rdata = cyc_q[31:0];
      OFF_CYCLE_HI: mmio_rdata = cyc_q[63:32];
      OFF_EXIT:     mmio_rdata = exit_code_q;
      OFF_CONS_ST:  mmio_rdata = status_rdata;
      OFF_ERR_ADDR: mmio_rdata = err_addr_q;
      default:      mmio_rdata = 32'd0;
    endcase
  end

  always_comb begin
    if (in_mmio) begin
      rd_word = mmio_rdata;
    end else if (in_ram) begin
      rd_word = ram_q[ram_idx];
    end else begin
      rd_word = 32'd0;
    end
    rd_shift = rd_word >> {lane, 3'b000};
    case (mem_sizeM)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  rd_ext = rd_word;
      3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
      3'b101:  rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = 32'd0;
    endcase
    ReadDataM = legal ? rd_ext : 32'd0;
  end

endmodule
